// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues one instruction-bus request at a time and
// queues responses for decode. Define FETCH_PERF_CNT_EN to add performance counters.
package fetch_unit_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          IBUF_DEPTH = 4,
    parameter logic [63:0] PC_STEP    = 64'd4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output ibus_req_t   ireq_o,
    input  ibus_resp_t  iresp_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output fetch_data_t dataF_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetched_o,
    output logic [63:0] perf_bus_stall_o,
    output logic [63:0] perf_flushed_o
`endif
);
    localparam int PTR_W = $clog2(IBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_e;

    state_e           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [63:0]      reqAddr_q, reqAddr_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_data_t      ibuf_q [IBUF_DEPTH];
    logic             push;
    logic             pop;

    assign ireq_o      = '{valid: (state_q != IDLE), addr: reqAddr_q};
    assign out_valid_o = (count_q != '0);
    assign dataF_o     = ibuf_q[head_q];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        reqAddr_d = reqAddr_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        push      = 1'b0;
        pop       = out_valid_o && out_ready_i;

        case (state_q)
            IDLE: begin
                if (!redirect_valid_i && (count_q < DEPTH_CNT)) begin
                    reqAddr_d = pc_q;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (iresp_i.data_ok) begin
                    state_d = IDLE;
                    if (!redirect_valid_i) begin
                        push = 1'b1;
                        pc_d = reqAddr_q + PC_STEP;
                    end
                end else if (redirect_valid_i) begin
                    // The bus cannot cancel a request, so its answer must be swallowed.
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (iresp_i.data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            reqAddr_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                ibuf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            reqAddr_q <= reqAddr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            if (push) begin
                ibuf_q[tail_q] <= '{pc: reqAddr_q, raw_instr: iresp_i.data};
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perfFetched_q, perfBusStall_q, perfFlushed_q;

    assign perf_fetched_o   = perfFetched_q;
    assign perf_bus_stall_o = perfBusStall_q;
    assign perf_flushed_o   = perfFlushed_q;

    // Flush count is the occupancy at the moment of redirect, not what gets popped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perfFetched_q  <= '0;
            perfBusStall_q <= '0;
            perfFlushed_q  <= '0;
        end else begin
            if (push) begin
                perfFetched_q <= perfFetched_q + 64'd1;
            end
            if (ireq_o.valid && !iresp_i.data_ok) begin
                perfBusStall_q <= perfBusStall_q + 64'd1;
            end
            if (redirect_valid_i) begin
                perfFlushed_q <= perfFlushed_q + 64'(count_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed sequences, a vector table and a randomized run against a
// queue-based reference model. Perf counter checks compile in with FETCH_PERF_CNT_EN.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          DEPTH    = 4;

    typedef struct {
        logic [63:0] redirectPc;
        int          latency;
        logic [31:0] data;
        logic [63:0] expNextAddr;
    } vec_t;

    logic        clk;
    logic        rstN;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirectValid;
    logic [63:0] redirectPc;
    logic        outValid;
    logic        outReady;
    fetch_data_t dataF;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perfFetched, perfBusStall, perfFlushed;
`endif

    int compareCount = 0;
    int failCount    = 0;

    fetch_data_t mQueue[$];
    logic [63:0] mPc, mAddr;
    bit          mInFlight, mStale;
    longint      mFetched, mStall, mFlushed;

    fetch_unit #(.RESET_PC(RESET_PC), .IBUF_DEPTH(DEPTH), .PC_STEP(64'd4)) dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .ireq_o          (ireq),
        .iresp_i         (iresp),
        .redirect_valid_i(redirectValid),
        .redirect_pc_i   (redirectPc),
        .out_valid_o     (outValid),
        .out_ready_i     (outReady),
        .dataF_o         (dataF)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o  (perfFetched),
        .perf_bus_stall_o(perfBusStall),
        .perf_flushed_o  (perfFlushed)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic dok, input logic [31:0] data,
                                 input logic redir, input logic [63:0] rpc);
        outReady      = ready;
        iresp.data_ok = dok;
        iresp.data    = data;
        redirectValid = redir;
        redirectPc    = rpc;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
        repeat (2) @(negedge clk);
        checkOutput("reset ireq.valid", ireq.valid, 1'b0);
        checkOutput("reset out_valid", outValid, 1'b0);
        checkOutput("reset dataF", dataF, 96'h0);
        rstN = 1'b1;
    endtask

    task automatic waitForRequest(input string name, input logic [63:0] expAddr, output int waited);
        waited = 0;
        while (!ireq.valid && waited < 40) begin
            tick();
            waited++;
        end
        checkOutput({name, " req valid"}, ireq.valid, 1'b1);
        checkOutput({name, " req addr"}, ireq.addr, expAddr);
    endtask

    task automatic serveFetch(input string name, input int lat, input logic [31:0] data,
                              input logic [63:0] expAddr, output int waited);
        waitForRequest(name, expAddr, waited);
        for (int i = 0; i < lat; i++) begin
            tick();
        end
        checkOutput({name, " addr held"}, ireq.addr, expAddr);
        iresp.data_ok = 1'b1;
        iresp.data    = data;
        tick();
        iresp.data_ok = 1'b0;
    endtask

    // Transaction view: a queue of fetched words, one optional outstanding request.
    task automatic modelStep(input logic ready, input logic dok, input logic [31:0] data,
                             input logic redir, input logic [63:0] rpc);
        int  sizeBefore;
        bit  doPop;
        sizeBefore = mQueue.size();
        doPop      = (sizeBefore != 0) && ready;
        if (mInFlight && !dok) mStall++;
        if (redir) begin
            mFlushed += sizeBefore;
            mQueue.delete();
            mPc = rpc;
            if (mInFlight) begin
                if (dok) begin
                    mInFlight = 0;
                    mStale    = 0;
                end else begin
                    mStale = 1;
                end
            end
        end else begin
            if (mInFlight && dok) begin
                if (!mStale) begin
                    mQueue.push_back('{pc: mAddr, raw_instr: data});
                    mPc = mAddr + 64'd4;
                    mFetched++;
                end
                mInFlight = 0;
                mStale    = 0;
            end else if (!mInFlight && sizeBefore < DEPTH) begin
                mInFlight = 1;
                mAddr     = mPc;
            end
            if (doPop) void'(mQueue.pop_front());
        end
    endtask

    initial begin
        vec_t        vecs[4];
        int          w;
        int          seen;
        logic [63:0] expAddr;
        logic        rReady, rDok, rRedir;
        logic [31:0] rData;
        logic [63:0] rPc;

        vecs[0] = '{64'h0000_0000_0000_1000, 1, 32'h0000_0013, 64'h0000_0000_0000_1004};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0000_006F, 64'h0000_0000_0000_0000};
        vecs[2] = '{64'h0000_0000_0000_2000, 3, 32'hDEAD_BEEF, 64'h0000_0000_0000_2004};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFC, 2, 32'h1234_5678, 64'h8000_0000_0000_0000};

        iresp = '0;
        doReset();
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expAddr = RESET_PC + 64'(4 * i);
            serveFetch("t1 fetch", 2, 32'h0000_0013, expAddr, w);
            checkOutput("t1 issue bubble", w, 1);
            checkOutput("t1 out_valid", outValid, 1'b1);
            checkOutput("t1 dataF", dataF, {expAddr, 32'h0000_0013});
        end

        doReset();
        for (int i = 0; i < 4; i++) begin
            serveFetch("t2 fill", 0, 32'h100 + i, RESET_PC + 64'(4 * i), w);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (ireq.valid) seen++;
            tick();
        end
        checkOutput("t2 full no request", seen, 0);
        checkOutput("t2 full out_valid", outValid, 1'b1);
        checkOutput("t2 full head", dataF, {RESET_PC, 32'h100});
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput("t2 popped head", dataF, {RESET_PC + 64'd4, 32'h101});
        checkOutput("t2 issue waits a cycle", ireq.valid, 1'b0);
        tick();
        checkOutput("t2 refill valid", ireq.valid, 1'b1);
        checkOutput("t2 refill addr", ireq.addr, RESET_PC + 64'h10);
        iresp.data_ok = 1'b1;
        iresp.data    = 32'h104;
        tick();
        iresp.data_ok = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (ireq.valid) seen++;
            tick();
        end
        checkOutput("t2 exactly one refill", seen, 0);
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2 drain order", dataF, {RESET_PC + 64'(4 * (i + 1)), 32'h101 + 32'(i)});
            tick();
        end
        outReady = 1'b0;
        rstN = 1'b0;
        #1;
        checkOutput("t2 async reset ireq.valid", ireq.valid, 1'b0);
        checkOutput("t2 async reset dataF", dataF, 96'h0);

        doReset();
        serveFetch("t3 a", 0, 32'h13, RESET_PC, w);
        serveFetch("t3 b", 0, 32'h13, RESET_PC + 64'd4, w);
        waitForRequest("t3 c", RESET_PC + 64'd8, w);
        redirectValid = 1'b1;
        redirectPc    = 64'h1000;
        tick();
        redirectValid = 1'b0;
        checkOutput("t3 flushed", outValid, 1'b0);
        checkOutput("t3 stale req held", ireq.valid, 1'b1);
        checkOutput("t3 stale addr held", ireq.addr, RESET_PC + 64'd8);
        tick();
        tick();
        iresp.data_ok = 1'b1;
        iresp.data    = 32'hDEAD_BEEF;
        tick();
        iresp.data_ok = 1'b0;
        checkOutput("t3 stale dropped", outValid, 1'b0);
        checkOutput("t3 idle after discard", ireq.valid, 1'b0);
        serveFetch("t3 new", 1, 32'h93, 64'h1000, w);
        checkOutput("t3 new out_valid", outValid, 1'b1);
        checkOutput("t3 new head", dataF, {64'h1000, 32'h93});

        doReset();
        outReady = 1'b1;
        serveFetch("t4 a", 0, 32'h13, RESET_PC, w);
        waitForRequest("t4 b", RESET_PC + 64'd4, w);
        iresp.data_ok = 1'b1;
        iresp.data    = 32'h0000_0BAD;
        redirectValid = 1'b1;
        redirectPc    = 64'h2000;
        tick();
        iresp.data_ok = 1'b0;
        redirectValid = 1'b0;
        checkOutput("t4 no push", outValid, 1'b0);
        checkOutput("t4 idle", ireq.valid, 1'b0);
        tick();
        checkOutput("t4 next valid", ireq.valid, 1'b1);
        checkOutput("t4 next addr", ireq.addr, 64'h2000);

        for (int v = 0; v < 4; v++) begin
            doReset();
            outReady      = 1'b1;
            redirectValid = 1'b1;
            redirectPc    = vecs[v].redirectPc;
            tick();
            redirectValid = 1'b0;
            checkOutput("tbl no issue on redirect", ireq.valid, 1'b0);
            serveFetch("tbl fetch", vecs[v].latency, vecs[v].data, vecs[v].redirectPc, w);
            checkOutput("tbl dataF", dataF, {vecs[v].redirectPc, vecs[v].data});
            waitForRequest("tbl next", vecs[v].expNextAddr, w);
        end

`ifdef FETCH_PERF_CNT_EN
        doReset();
        serveFetch("perf 0", 1, 32'h13, RESET_PC, w);
        serveFetch("perf 1", 2, 32'h13, RESET_PC + 64'd4, w);
        serveFetch("perf 2", 0, 32'h13, RESET_PC + 64'd8, w);
        serveFetch("perf 3", 3, 32'h13, RESET_PC + 64'd12, w);
        outReady = 1'b1;
        tick();
        outReady      = 1'b0;
        redirectValid = 1'b1;
        redirectPc    = 64'h3000;
        tick();
        redirectValid = 1'b0;
        checkOutput("perf fetched", perfFetched, 64'd4);
        checkOutput("perf flushed", perfFlushed, 64'd3);
        checkOutput("perf bus stall", perfBusStall, 64'd6);
`endif

        doReset();
        mQueue.delete();
        mPc       = RESET_PC;
        mAddr     = '0;
        mInFlight = 0;
        mStale    = 0;
        mFetched  = 0;
        mStall    = 0;
        mFlushed  = 0;
        for (int c = 0; c < 1500; c++) begin
            checkOutput("rnd out_valid", outValid, mQueue.size() != 0);
            if (mQueue.size() != 0) checkOutput("rnd dataF", dataF, mQueue[0]);
            checkOutput("rnd ireq.valid", ireq.valid, mInFlight);
            if (mInFlight) checkOutput("rnd ireq.addr", ireq.addr, mAddr);
            rReady = ($urandom_range(0, 99) < 60);
            rDok   = mInFlight && ($urandom_range(0, 99) < 45);
            rData  = $urandom();
            rRedir = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0:       rPc = {$urandom(), $urandom()} & ~64'h3;
                1:       rPc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
                2:       rPc = RESET_PC;
                default: rPc = 64'(4 * $urandom_range(0, 255));
            endcase
            applyStimulus(rReady, rDok, rData, rRedir, rPc);
            modelStep(rReady, rDok, rData, rRedir, rPc);
            tick();
        end
`ifdef FETCH_PERF_CNT_EN
        checkOutput("rnd perf fetched", perfFetched, 64'(mFetched));
        checkOutput("rnd perf stall", perfBusStall, 64'(mStall));
        checkOutput("rnd perf flushed", perfFlushed, 64'(mFlushed));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
